// File: rtl/rfid_pkg.sv
// Shared types and constants for the PCD frame receive path.
package rfid_pkg;
  localparam int QUARTERS       = 4;
  localparam int BITS_PER_GROUP = 9;
  localparam int MAX_FRAME_BITS = 40;

  typedef enum logic [1:0] {
    SYM_ONE,
    SYM_ZERO,
    SYM_EOF,
    SYM_ILLEGAL
  } sym_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    RECOVER,
    DONE
  } state_e;
endpackage

// File: rtl/picc_symbol_slicer.sv
// Classifies one bit period (four on/off samples, q0 in bit 0) into a symbol.
module picc_symbol_slicer
  import rfid_pkg::*;
(
  input  logic [QUARTERS-1:0] on_q,
  input  logic                prev_bit,
  output sym_e                sym
);
  // Mid-period pause is a one, leading pause is a zero; a pause-free period
  // is a zero only right after a one, otherwise it closes the frame.
  always_comb begin
    sym = SYM_ILLEGAL;
    if (on_q == 4'b1011)      sym = SYM_ONE;
    else if (on_q == 4'b1110) sym = SYM_ZERO;
    else if (on_q == 4'b1111) sym = prev_bit ? SYM_ZERO : SYM_EOF;
  end
endmodule

// File: rtl/pcd_frame_decoder.sv
// Decodes quarter-bit envelope samples into bytes with parity and framing checks.
module pcd_frame_decoder
  import rfid_pkg::*;
#(
  parameter int MAX_BYTES     = 5,
  parameter int RECOVER_TICKS = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic signed [31:0]        amp_in,
  output logic [MAX_FRAME_BITS-1:0] data_out,
  output logic [2:0]                num_bytes_out,
  output logic                      frame_done,
  output logic                      parity_err,
  output logic                      coding_err,
  output logic                      busy
);
  localparam int             RW       = $clog2(RECOVER_TICKS + 1);
  localparam logic [5:0]     OVF_BITS = 6'(MAX_BYTES * BITS_PER_GROUP);
  localparam logic [RW-1:0]  REC_LAST = RW'(RECOVER_TICKS - 1);

  state_e        state, state_nxt;
  sym_e          sym;
  logic          on, is_q3, ovf, rec_exit, data_bit;
  logic [1:0]    q;
  logic [2:0]    smp;
  logic          prev_bit;
  logic [5:0]    bit_cnt;
  logic [3:0]    grp_pos;
  logic          par_acc, trail_nz;
  logic [RW-1:0] rec_cnt;
  logic [5:0]    wr_idx;

  assign on       = (amp_in != 32'sd0);
  assign is_q3    = (q == 2'd3);
  // Next data bit would open a group past the largest frame.
  assign ovf      = (bit_cnt >= OVF_BITS);
  assign rec_exit = on && (rec_cnt == REC_LAST);
  assign data_bit = (sym == SYM_ONE);
  assign wr_idx   = {num_bytes_out, 3'b000} + {2'b00, grp_pos};

  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);

  picc_symbol_slicer u_slicer (
    .on_q    ({on, smp}),
    .prev_bit(prev_bit),
    .sym     (sym)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; symbols are acted on in the q3 cycle itself.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!on) state_nxt = START;
      START:   state_nxt = on ? BITS : RECOVER;
      BITS: begin
        if (is_q3) begin
          case (sym)
            SYM_ILLEGAL: state_nxt = RECOVER;
            SYM_EOF:     state_nxt = DONE;
            default:     if (ovf) state_nxt = RECOVER;
          endcase
        end
      end
      RECOVER: if (rec_exit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample history, bit/byte accumulation, error flags and recovery counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_out      <= '0;
      num_bytes_out <= '0;
      parity_err    <= 1'b0;
      coding_err    <= 1'b0;
      q             <= '0;
      smp           <= '0;
      prev_bit      <= 1'b0;
      bit_cnt       <= '0;
      grp_pos       <= '0;
      par_acc       <= 1'b0;
      trail_nz      <= 1'b0;
      rec_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!on) begin
            data_out      <= '0;
            num_bytes_out <= '0;
            parity_err    <= 1'b0;
            coding_err    <= 1'b0;
            q             <= '0;
            bit_cnt       <= '0;
            grp_pos       <= '0;
            par_acc       <= 1'b0;
            trail_nz      <= 1'b0;
            rec_cnt       <= '0;
            prev_bit      <= 1'b1;
          end
        end
        START: begin
          q       <= '0;
          rec_cnt <= '0;
          if (!on) coding_err <= 1'b1;
        end
        BITS: begin
          if (!is_q3) begin
            smp <= {on, smp[2:1]};
            q   <= q + 2'd1;
          end else begin
            q       <= '0;
            rec_cnt <= '0;
            case (sym)
              SYM_ILLEGAL: coding_err <= 1'b1;
              SYM_EOF: if (trail_nz || num_bytes_out == 3'd0) coding_err <= 1'b1;
              default: begin
                if (ovf) begin
                  coding_err <= 1'b1;
                end else begin
                  prev_bit <= data_bit;
                  if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                  if (grp_pos < 4'd8) begin
                    if (wr_idx < 6'(MAX_FRAME_BITS)) data_out[wr_idx] <= data_bit;
                    par_acc  <= par_acc ^ data_bit;
                    trail_nz <= trail_nz | data_bit;
                    grp_pos  <= grp_pos + 4'd1;
                  end else begin
                    if (data_bit != par_acc) parity_err <= 1'b1;
                    par_acc       <= 1'b0;
                    trail_nz      <= 1'b0;
                    grp_pos       <= '0;
                    num_bytes_out <= num_bytes_out + 3'd1;
                  end
                end
              end
            endcase
          end
        end
        RECOVER: rec_cnt <= on ? rec_cnt + RW'(1) : '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pcd_frame_decoder.sv
// Directed and randomized frames against a byte-level reference model.
module tb_pcd_frame_decoder;
  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic signed [31:0] amp_in = 32'sd1;
  logic [39:0]        data_out;
  logic [2:0]         num_bytes_out;
  logic               frame_done, parity_err, coding_err, busy;

  int checks = 0, errors = 0;
  int cyc = 0, fd_cnt = 0, fd_on = -1, on_run = 0, ce_cyc = -1, mark_cyc = -1;
  int bit_idx = 0;
  logic eof_fd;
  bit prev;

  always #5 clk_in = ~clk_in;

  pcd_frame_decoder dut (
    .clk_in(clk_in), .rst_in(rst_in), .amp_in(amp_in),
    .data_out(data_out), .num_bytes_out(num_bytes_out), .frame_done(frame_done),
    .parity_err(parity_err), .coding_err(coding_err), .busy(busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One quarter-bit sample; outputs are observed 1 time unit after the edge.
  task automatic put(input bit on);
    logic signed [31:0] v;
    v = $urandom;
    if (v == 32'sd0) v = 32'sd7;
    amp_in = on ? v : 32'sd0;
    @(posedge clk_in); #1;
    cyc++;
    if (on) on_run++; else on_run = 0;
    if (frame_done) begin fd_cnt++; fd_on = on_run; end
    if (coding_err && ce_cyc < 0) ce_cyc = cyc;
  endtask

  // Transmit one bit with the modified-Miller rule; glitch forces q1 off.
  task automatic send_bit(input bit b, input bit glitch);
    bit [3:0] p;
    if (b)         p = 4'b1011;
    else if (prev) p = 4'b1111;
    else           p = 4'b1110;
    if (glitch) p[1] = 1'b0;
    for (int i = 0; i < 4; i++) put(p[i]);
    if (bit_idx == 45) mark_cyc = cyc;
    bit_idx++;
    prev = b;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input logic [7:0] flip,
                            input int glitch_at, input int abort_at);
    bit stop;
    stop = 1'b0;
    eof_fd = 1'b0;
    put(1'b0); put(1'b1);
    chk("busy_mid", busy, 1);
    prev = 1'b1; bit_idx = 0;
    foreach (bytes[k]) begin
      for (int j = 0; j < 9; j++) begin
        bit v;
        v = (j < 8) ? bytes[k][j] : (^bytes[k] ^ flip[k]);
        if (bit_idx == abort_at) stop = 1'b1;
        if (!stop) send_bit(v, bit_idx == glitch_at);
      end
    end
    if (!stop) begin
      if (prev) send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) put(1'b1);
      eof_fd = frame_done;
    end
  endtask

  task automatic wait_done(input int start_fd, input string tag);
    int n;
    n = 0;
    while (fd_cnt == start_fd && n < 60) begin put(1'b1); n++; end
    chk({tag, "_timeout"}, 64'(fd_cnt != start_fd), 1);
    repeat (3) put(1'b1);
    chk({tag, "_pulses"}, 64'(fd_cnt - start_fd), 1);
  endtask

  task automatic check_frame(input string tag, input logic [39:0] ed, input int en,
                             input logic epe, input logic ece);
    chk({tag, "_data"}, data_out, ed);
    chk({tag, "_num"}, num_bytes_out, 64'(en));
    chk({tag, "_perr"}, parity_err, epe);
    chk({tag, "_cerr"}, coding_err, ece);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [7:0] bq[$];
    int f0;

    #2 rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_num", num_bytes_out, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_cerr", coding_err, 0);
    chk("rst_busy", busy, 0);
    rst_in = 1'b1;
    put(1'b1); put(1'b1);

    // Single byte 0xA5.
    bq = '{8'hA5}; f0 = fd_cnt;
    send_frame(bq, 8'h00, -1, -1);
    chk("a5_latency", eof_fd, 1);
    wait_done(f0, "a5");
    check_frame("a5", 40'hA5, 1, 1'b0, 1'b0);

    // Two bytes; an off sample during DONE must not start a frame.
    bq = '{8'h26, 8'h93}; f0 = fd_cnt;
    send_frame(bq, 8'h00, -1, -1);
    chk("two_latency", eof_fd, 1);
    put(1'b0);
    wait_done(f0, "two");
    check_frame("two", 40'h9326, 2, 1'b0, 1'b0);

    // Inverted parity bit.
    bq = '{8'hA5}; f0 = fd_cnt;
    send_frame(bq, 8'h01, -1, -1);
    wait_done(f0, "par");
    check_frame("par", 40'hA5, 1, 1'b1, 1'b0);

    // Illegal symbol at bit 3, then recovery after 8 on-samples.
    f0 = fd_cnt; fd_on = -1;
    send_frame(bq, 8'h00, 3, -1);
    wait_done(f0, "glitch");
    chk("glitch_cerr", coding_err, 1);
    chk("glitch_rec_ticks", 64'(fd_on), 8);
    f0 = fd_cnt;
    send_frame(bq, 8'h00, -1, -1);
    wait_done(f0, "after_glitch");
    check_frame("after_glitch", 40'hA5, 1, 1'b0, 1'b0);

    // Start bit not followed by an on sample: exactly RECOVER_TICKS on-samples to DONE.
    f0 = fd_cnt;
    put(1'b0); put(1'b0);
    repeat (7) put(1'b1);
    chk("start_err_early", 64'(fd_cnt - f0), 0);
    put(1'b1);
    chk("start_err_done", 64'(fd_cnt - f0), 1);
    repeat (3) put(1'b1);
    chk("start_err_cerr", coding_err, 1);
    chk("start_err_num", num_bytes_out, 0);

    // Empty frame: start, one zero, EOF -> no complete group.
    f0 = fd_cnt;
    put(1'b0); put(1'b1);
    repeat (8) put(1'b1);
    chk("empty_latency", frame_done, 1);
    wait_done(f0, "empty");
    check_frame("empty", 40'h0, 0, 1'b0, 1'b1);

    // Six bytes overflow: error appears at the first data bit of byte 6.
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    f0 = fd_cnt; ce_cyc = -1; mark_cyc = -1;
    send_frame(bq, 8'h00, -1, -1);
    wait_done(f0, "ovf");
    chk("ovf_marked", 64'(mark_cyc > 0), 1);
    chk("ovf_cycle", 64'(ce_cyc), 64'(mark_cyc));
    check_frame("ovf", 40'hFFFFFFFFFF, 5, 1'b0, 1'b1);

    // Reset mid-byte of a three-byte frame.
    bq = '{8'h5A, 8'hC3, 8'h7E}; f0 = fd_cnt;
    send_frame(bq, 8'h00, -1, 13);
    rst_in = 1'b0;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_num", num_bytes_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_flags", {parity_err, coding_err, frame_done}, 0);
    for (int i = 0; i < 5; i++) put(i[0]);
    chk("arst_hold_data", data_out, 0);
    rst_in = 1'b1;
    put(1'b1); put(1'b1);
    chk("arst_no_pulse", 64'(fd_cnt - f0), 0);
    bq = '{8'h3C, 8'h81};
    send_frame(bq, 8'h00, -1, -1);
    wait_done(f0, "post_rst");
    check_frame("post_rst", 40'h813C, 2, 1'b0, 1'b0);

    // Random frames against the byte-level model.
    for (int it = 0; it < 8; it++) begin
      int n;
      logic [7:0] fl;
      logic [39:0] ed;
      logic lastp, ece;
      n = $urandom_range(1, 5);
      bq = {}; ed = '0;
      for (int k = 0; k < n; k++) begin
        bq.push_back(8'($urandom));
        ed = ed | (40'(bq[k]) << (8 * k));
      end
      fl = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, n - 1)) : 8'h00;
      lastp = ^bq[n-1] ^ fl[n-1];
      // A one in the last parity slot forces a closing zero, which opens a
      // sixth group when the frame is already full.
      ece = (n == 5) && lastp;
      f0 = fd_cnt;
      send_frame(bq, fl, -1, -1);
      if (!ece) chk("rnd_latency", eof_fd, 1);
      wait_done(f0, "rnd");
      check_frame("rnd", ed, n, fl != 8'h00, ece);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
